mem_port_arbiter: RTL

//  Shares the single backing-memory port between the instruction-cache refill path and the

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_arb_select.sv | 64 ++++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared FSM state encodings and requester owner codes for the memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Winner choice between instr and data requesters; fixed priority with starvation guard,
// or round robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter_arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   idle,
    input  logic   grant,
    input  logic   i_req,
    input  logic   d_req,
    output owner_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

    owner_t last_winner;

    always_comb begin
        if (i_req && d_req) begin
            winner = (last_winner == OWN_I) ? OWN_D : OWN_I;
        end else begin
            winner = d_req ? OWN_D : OWN_I;
        end
    end

    // Starts as instr so that data takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= OWN_I;
        end else if (idle && grant) begin
            last_winner <= winner;
        end
    end

`else

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    always_comb begin
        winner = (d_req && !(i_req && starve_cnt == LIM)) ? OWN_D : OWN_I;
    end

    // Counts data wins that left a waiting instr request behind; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (!i_req || (grant && winner == OWN_I)) begin
                starve_cnt <= '0;
            end else if (grant && starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instr refill and data miss/write-back; one transaction at a time,
// IDLE->BUSY->DONE, all outputs registered. Policy set by MEM_ARB_ROUND_ROBIN_EN (see arb_select).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;
    owner_t        winner;
    logic          grant;
    logic          timed_out;
    logic [TW-1:0] timeout_cnt;

    mem_port_arbiter_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_select (
        .clk    (clk),
        .rst_n  (rst_n),
        .idle   (state == ST_IDLE),
        .grant  (grant),
        .i_req  (i_req),
        .d_req  (d_req),
        .winner (winner)
    );

    assign timed_out = (TIMEOUT_CYCLES > 0) && (timeout_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready || timed_out) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The mem_* output registers double as the request latches for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWN_I;
            timeout_cnt <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            err         <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state   <= state_nxt;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner       <= winner;
                        timeout_cnt <= '0;
                        mem_req     <= 1'b1;
                        if (winner == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready || timed_out) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= !mem_ready;
                        if (owner == OWN_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
